// File: rtl/coproc_pkg.sv
// ---------------------------------------------------------------------------
// coproc_pkg
// Shared definitions for the zoom coprocessor. Used by the main sequencer,
// zoom_controller, vga_controller and the display driver.
//   state_e      : main sequencer states
//   img_state_e  : IMAGE_STATE codes sent to the VGA controller
//   alg_e        : zoom algorithm codes shown on the display
//   nextAlg()    : selector step, wrapping the last algorithm back to the first
// ---------------------------------------------------------------------------
package coproc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    IMG_ORIGINAL   = 2'd0,
    IMG_PROCESSING = 2'd1,
    IMG_PROCESSED  = 2'd2,
    IMG_ERROR      = 2'd3
  } img_state_e;

  typedef enum logic [1:0] {
    ALG_NN_ZOOM   = 2'd0,
    ALG_PIX_REP   = 2'd1,
    ALG_DECIMATE  = 2'd2,
    ALG_BLOCK_AVG = 2'd3
  } alg_e;

  // 20 ms at 50 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 262_144;

  // The 2-bit code wraps naturally from ALG_BLOCK_AVG to ALG_NN_ZOOM.
  function automatic alg_e nextAlg(input alg_e cur);
    return alg_e'(cur + 2'd1);
  endfunction

endpackage

// File: rtl/coproc_main_fsm_if.sv
// ---------------------------------------------------------------------------
// coproc_main_fsm_if
// Button, image_processing handshake and status signals of the coprocessor
// sequencer.
//   master modport (the sequencer):
//     in  RUN, ALGORITHM_SELECTOR : raw buttons, asynchronous to CLK
//     in  PROC_DONE               : one-cycle done pulse from image_processing
//     out PROC_START              : one-cycle start pulse to image_processing
//     out WREN, BUSY              : RAM write enable / run in flight
//     out ALG_SEL, ALGORITHM      : pending selection / algorithm of the run
//     out IMAGE_STATE, ERROR      : VGA image state / timeout flag
//   slave modport: the mirror view for the surrounding top level.
// ---------------------------------------------------------------------------
interface coproc_main_fsm_if;
  import coproc_pkg::*;

  logic       RUN;
  logic       ALGORITHM_SELECTOR;
  logic       PROC_DONE;
  logic       PROC_START;
  logic       WREN;
  logic       BUSY;
  alg_e       ALG_SEL;
  alg_e       ALGORITHM;
  img_state_e IMAGE_STATE;
  logic       ERROR;

  modport master (
    input  RUN, ALGORITHM_SELECTOR, PROC_DONE,
    output PROC_START, WREN, BUSY, ALG_SEL, ALGORITHM, IMAGE_STATE, ERROR
  );

  modport slave (
    output RUN, ALGORITHM_SELECTOR, PROC_DONE,
    input  PROC_START, WREN, BUSY, ALG_SEL, ALGORITHM, IMAGE_STATE, ERROR
  );

endinterface

// File: rtl/coproc_main_fsm_button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Synchronises a raw push button into the CLK domain and debounces it.
//   CLK, RESET : clock and synchronous active-high reset
//   BTN_RAW    : raw button level, asynchronous to CLK
//   BTN_LEVEL  : accepted (debounced) level
//   BTN_PRESS  : one-cycle pulse on each accepted rising edge
// The accepted level follows the synchronised input only after
// DEBOUNCE_CYCLES consecutive samples that differ from it.
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN_RAW,
  output logic BTN_LEVEL,
  output logic BTN_PRESS
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  // Two-flop synchroniser plus debounce state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      count_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= BTN_RAW;
      sync2_q <= sync1_q;
      count_q <= count_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  // The counter only advances while the input disagrees with the accepted
  // level; any agreeing sample (a bounce back) restarts the count from zero.
  // The last disagreeing sample flips the level and, on a rise, pulses press.
  always_comb begin
    count_d = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (count_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  assign BTN_LEVEL = level_q;
  assign BTN_PRESS = press_q;

endmodule

// File: rtl/coproc_main_fsm.sv
// ---------------------------------------------------------------------------
// coproc_main_fsm
// Top-level sequencer of the zoom coprocessor. Debounces RUN and
// ALGORITHM_SELECTOR, steps the pending algorithm selection, starts
// image_processing with a one-cycle pulse, holds RAM WREN for the run and
// waits for PROC_DONE. All outputs are registered.
//   CLK, RESET : clock and synchronous active-high reset
//   bus        : coproc_main_fsm_if.master (buttons, start/done, status)
// Parameters: DEBOUNCE_CYCLES (button stability time), TIMEOUT_CYCLES
// (maximum WAIT length).
// Optional feature macro COPROC_TIMEOUT_EN: adds the WAIT timeout counter and
// the ERROR state. Without it ERROR is constant 0 and WAIT lasts until done.
// ---------------------------------------------------------------------------
module coproc_main_fsm
  import coproc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input logic               CLK,
  input logic               RESET,
  coproc_main_fsm_if.master bus
);

  logic runPress, selPress;
  logic runLevel, selLevel;
  logic unusedLevels;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) runDebounce (
    .CLK       (CLK),
    .RESET     (RESET),
    .BTN_RAW   (bus.RUN),
    .BTN_LEVEL (runLevel),
    .BTN_PRESS (runPress)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) selDebounce (
    .CLK       (CLK),
    .RESET     (RESET),
    .BTN_RAW   (bus.ALGORITHM_SELECTOR),
    .BTN_LEVEL (selLevel),
    .BTN_PRESS (selPress)
  );

  // Only the press pulses drive the sequencer; the levels are not needed here.
  assign unusedLevels = runLevel ^ selLevel;

  state_e     state_q, state_d;
  alg_e       algSel_q, algSel_d;
  alg_e       algorithm_q, algorithm_d;
  img_state_e imgState_q, imgState_d;
  logic       procStart_q, procStart_d;
  logic       wren_q, wren_d;
  logic       busy_q, busy_d;

`ifdef COPROC_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] waitCnt_q, waitCnt_d;
  logic            error_q, error_d;
`else
  localparam bit unusedTimeout = (TIMEOUT_CYCLES != 0);
`endif

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      algSel_q    <= ALG_NN_ZOOM;
      algorithm_q <= ALG_NN_ZOOM;
      imgState_q  <= IMG_ORIGINAL;
      procStart_q <= 1'b0;
      wren_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef COPROC_TIMEOUT_EN
      waitCnt_q   <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      algSel_q    <= algSel_d;
      algorithm_q <= algorithm_d;
      imgState_q  <= imgState_d;
      procStart_q <= procStart_d;
      wren_q      <= wren_d;
      busy_q      <= busy_d;
`ifdef COPROC_TIMEOUT_EN
      waitCnt_q   <= waitCnt_d;
      error_q     <= error_d;
`endif
    end
  end

  // Outputs are computed for the state being entered, so each output register
  // already holds the value of the next state when that state begins. This is
  // what puts PROC_START one cycle after the run press and drops WREN/BUSY one
  // cycle after PROC_DONE. START always moves on to WAIT, so a PROC_DONE
  // arriving during START is never looked at.
  always_comb begin
    state_d     = state_q;
    algSel_d    = algSel_q;
    algorithm_d = algorithm_q;
    imgState_d  = imgState_q;
    procStart_d = 1'b0;
    wren_d      = 1'b0;
    busy_d      = 1'b0;
`ifdef COPROC_TIMEOUT_EN
    waitCnt_d   = waitCnt_q;
    error_d     = error_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (selPress) begin
          algSel_d = nextAlg(algSel_q);
        end
        // The run latches the selection as it was before a simultaneous
        // selector press takes effect.
        if (runPress) begin
          state_d     = ST_START;
          procStart_d = 1'b1;
          algorithm_d = algSel_q;
          wren_d      = 1'b1;
          busy_d      = 1'b1;
          imgState_d  = IMG_PROCESSING;
`ifdef COPROC_TIMEOUT_EN
          error_d     = 1'b0;
`endif
        end
      end

      ST_START: begin
        state_d = ST_WAIT;
        wren_d  = 1'b1;
        busy_d  = 1'b1;
`ifdef COPROC_TIMEOUT_EN
        waitCnt_d = '0;
`endif
      end

      ST_WAIT: begin
        if (bus.PROC_DONE) begin
          state_d    = ST_DONE;
          imgState_d = IMG_PROCESSED;
        end
`ifdef COPROC_TIMEOUT_EN
        else if (waitCnt_q == TO_LAST) begin
          state_d    = ST_ERROR;
          imgState_d = IMG_ERROR;
          error_d    = 1'b1;
        end
`endif
        else begin
          wren_d = 1'b1;
          busy_d = 1'b1;
`ifdef COPROC_TIMEOUT_EN
          waitCnt_d = waitCnt_q + 1'b1;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.PROC_START  = procStart_q;
  assign bus.WREN        = wren_q;
  assign bus.BUSY        = busy_q;
  assign bus.ALG_SEL     = algSel_q;
  assign bus.ALGORITHM   = algorithm_q;
  assign bus.IMAGE_STATE = imgState_q;
`ifdef COPROC_TIMEOUT_EN
  assign bus.ERROR       = error_q;
`else
  assign bus.ERROR       = 1'b0;
`endif

endmodule

// File: tb/tb_coproc_main_fsm.sv
// ---------------------------------------------------------------------------
// tb_coproc_main_fsm
// Self-checking bench for coproc_main_fsm with DEBOUNCE_CYCLES=4 and
// TIMEOUT_CYCLES=32. A reference model keeps the behaviour in terms of
// button sample windows and run bookkeeping; each predicted start is queued
// and popped by the monitor when the DUT raises PROC_START. Honors the
// COPROC_TIMEOUT_EN macro the same way as the design.
// ---------------------------------------------------------------------------
module tb_coproc_main_fsm;
  import coproc_pkg::*;

  localparam int DEB = 4;
  localparam int TO  = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  coproc_main_fsm_if bus ();

  coproc_main_fsm #(
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cyc;
    int alg;
  } start_t;

  start_t sbq[$];

  // Reference model state.
  int cycleCnt = 0;
  bit btnHist[2][DEB+2];
  bit btnLevel[2];
  bit btnPress[2];
  bit mInFlight;
  bit mStartCycle;
  bit mErr;
  int mWaitCycles;
  int mImg;
  int mAlgSel;
  int mAlg;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Drive all inputs and hold them for n clock edges; returns 1 time unit
  // after the last edge.
  task automatic applyStimulus(input bit r, input bit run, input bit sel, input bit done, input int n);
    rst = r;
    bus.RUN = run;
    bus.ALGORITHM_SELECTOR = sel;
    bus.PROC_DONE = done;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pressRun(input bit alsoSel);
    applyStimulus(0, 1, alsoSel, 0, $urandom_range(DEB + 2, DEB + 6));
    applyStimulus(0, 0, 0, 0, $urandom_range(DEB + 2, DEB + 6));
  endtask

  task automatic pressSel();
    applyStimulus(0, 0, 1, 0, $urandom_range(DEB + 2, DEB + 6));
    applyStimulus(0, 0, 0, 0, $urandom_range(DEB + 2, DEB + 6));
  endtask

  task automatic pulseDone();
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 2);
  endtask

  // Button model: a press is accepted when the last DEB samples that reached
  // the debounce stage (raw values two edges old) all disagree with the level.
  task automatic stepButton(input int b, input bit raw, input bit r);
    bit allDiff;
    btnPress[b] = 1'b0;
    if (r) begin
      for (int i = 0; i < DEB + 2; i++) btnHist[b][i] = 1'b0;
      btnLevel[b] = 1'b0;
    end else begin
      for (int i = DEB + 1; i > 0; i--) btnHist[b][i] = btnHist[b][i-1];
      btnHist[b][0] = raw;
      allDiff = 1'b1;
      for (int i = 2; i < DEB + 2; i++) begin
        if (btnHist[b][i] == btnLevel[b]) allDiff = 1'b0;
      end
      if (allDiff) begin
        btnLevel[b] = ~btnLevel[b];
        btnPress[b] = btnLevel[b];
      end
    end
  endtask

  // Run bookkeeping for one clock edge, using the press pulses visible
  // during the cycle before the edge.
  task automatic modelEdge(input bit r, input bit run, input bit sel, input bit done);
    bit pr;
    bit ps;
    int nextSel;
    start_t s;
    pr = btnPress[0];
    ps = btnPress[1];
    stepButton(0, run, r);
    stepButton(1, sel, r);
    cycleCnt++;
    if (r) begin
      mInFlight   = 1'b0;
      mStartCycle = 1'b0;
      mErr        = 1'b0;
      mWaitCycles = 0;
      mImg        = 0;
      mAlgSel     = 0;
      mAlg        = 0;
    end else if (mStartCycle) begin
      mStartCycle = 1'b0;
      mWaitCycles = 0;
    end else if (mInFlight) begin
      mWaitCycles++;
      if (done) begin
        mInFlight = 1'b0;
        mImg      = 2;
      end
`ifdef COPROC_TIMEOUT_EN
      else if (mWaitCycles == TO) begin
        mInFlight = 1'b0;
        mImg      = 3;
        mErr      = 1'b1;
      end
`endif
    end else begin
      nextSel = ps ? (mAlgSel + 1) % 4 : mAlgSel;
      if (pr) begin
        mStartCycle = 1'b1;
        mInFlight   = 1'b1;
        mAlg        = mAlgSel;
        mImg        = 1;
        mErr        = 1'b0;
        s.cyc = cycleCnt;
        s.alg = mAlgSel;
        sbq.push_back(s);
      end
      mAlgSel = nextSel;
    end
  endtask

  // Model advances on every rising edge with the inputs the DUT samples there.
  initial begin
    forever begin
      @(posedge clk);
      modelEdge(rst, bus.RUN, bus.ALGORITHM_SELECTOR, bus.PROC_DONE);
    end
  end

  // Monitor: compares outputs on the falling edge and pops the start queue.
  initial begin
    start_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (bus.PROC_START === 1'b1) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL start_unexpected: got PROC_START=1 want no start (cycle %0d)", cycleCnt);
        end else begin
          e = sbq.pop_front();
          checkOutput("start_cycle", cycleCnt, e.cyc);
          checkOutput("start_algorithm", bus.ALGORITHM, e.alg);
        end
      end
      checkOutput("proc_start", bus.PROC_START, mStartCycle);
      checkOutput("wren", bus.WREN, mInFlight);
      checkOutput("busy", bus.BUSY, mInFlight);
      checkOutput("image_state", bus.IMAGE_STATE, mImg);
      checkOutput("alg_sel", bus.ALG_SEL, mAlgSel);
      checkOutput("algorithm", bus.ALGORITHM, mAlg);
      checkOutput("error", bus.ERROR, mErr);
    end
  end

  // Directed scenarios followed by a randomised phase.
  initial begin
    bit r;
    bit run;
    bit sel;

    applyStimulus(1, 0, 0, 0, 3);
    checkOutput("reset_proc_start", bus.PROC_START, 0);
    checkOutput("reset_wren", bus.WREN, 0);
    checkOutput("reset_busy", bus.BUSY, 0);
    checkOutput("reset_alg_sel", bus.ALG_SEL, 0);
    checkOutput("reset_algorithm", bus.ALGORITHM, 0);
    checkOutput("reset_image_state", bus.IMAGE_STATE, 0);
    checkOutput("reset_error", bus.ERROR, 0);
    applyStimulus(0, 0, 0, 0, 2);

    $display("[TB] run held 10 cycles");
    applyStimulus(0, 1, 0, 0, 10);
    applyStimulus(0, 0, 0, 0, 8);
    checkOutput("t1_image_state", bus.IMAGE_STATE, 1);
    checkOutput("t1_algorithm", bus.ALGORITHM, 0);
    checkOutput("t1_busy", bus.BUSY, 1);
    pulseDone();
    checkOutput("t1_done_image_state", bus.IMAGE_STATE, 2);
    checkOutput("t1_done_wren", bus.WREN, 0);

    $display("[TB] bouncing run button");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 0, 0, 2);
      applyStimulus(0, 0, 0, 0, 2);
    end
    applyStimulus(0, 0, 0, 0, 8);
    checkOutput("t2_busy", bus.BUSY, 0);
    checkOutput("t2_image_state", bus.IMAGE_STATE, 2);

    $display("[TB] selector x5 then run");
    for (int i = 0; i < 5; i++) pressSel();
    checkOutput("t3_alg_sel", bus.ALG_SEL, 1);
    pressRun(1'b0);
    checkOutput("t3_algorithm", bus.ALGORITHM, 1);
    checkOutput("t3_busy", bus.BUSY, 1);
    pressSel();
    checkOutput("t3_sel_in_wait", bus.ALG_SEL, 1);

`ifndef COPROC_TIMEOUT_EN
    applyStimulus(0, 0, 0, 0, 25);
`endif
    pulseDone();
    checkOutput("t4_image_state", bus.IMAGE_STATE, 2);
    checkOutput("t4_wren", bus.WREN, 0);
    checkOutput("t4_busy", bus.BUSY, 0);
    pressRun(1'b1);
    checkOutput("t4_algorithm_pre_inc", bus.ALGORITHM, 1);
    checkOutput("t4_alg_sel_post_inc", bus.ALG_SEL, 2);
    pulseDone();

    $display("[TB] reset during wait");
    applyStimulus(0, 1, 0, 0, 10);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("t5_wren", bus.WREN, 0);
    checkOutput("t5_busy", bus.BUSY, 0);
    checkOutput("t5_image_state", bus.IMAGE_STATE, 0);
    checkOutput("t5_algorithm", bus.ALGORITHM, 0);
    checkOutput("t5_alg_sel", bus.ALG_SEL, 0);
    applyStimulus(0, 0, 0, 0, 3);

    $display("[TB] no done for a long wait");
    pressRun(1'b0);
    applyStimulus(0, 0, 0, 0, 40);
`ifdef COPROC_TIMEOUT_EN
    checkOutput("t6_error", bus.ERROR, 1);
    checkOutput("t6_image_state", bus.IMAGE_STATE, 3);
    checkOutput("t6_busy", bus.BUSY, 0);
    pressRun(1'b0);
    checkOutput("t6_rerun_error", bus.ERROR, 0);
    checkOutput("t6_rerun_busy", bus.BUSY, 1);
`else
    checkOutput("t6_error", bus.ERROR, 0);
    checkOutput("t6_busy", bus.BUSY, 1);
    checkOutput("t6_image_state", bus.IMAGE_STATE, 1);
`endif
    pulseDone();

    $display("[TB] random phase");
    for (int i = 0; i < 120; i++) begin
      r   = ($urandom_range(0, 39) == 0);
      run = $urandom_range(0, 1);
      sel = $urandom_range(0, 1);
      applyStimulus(r, run, sel, ($urandom_range(0, 5) == 0), 1);
      applyStimulus(0, run, sel, 0, $urandom_range(1, 10));
    end

    applyStimulus(0, 0, 0, 0, 12);
    checkOutput("start_queue_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
